// File: rtl/rv32i_mem_pkg.sv
// Shared types for the RV32I single-port memory arbiter: FSM state encoding,
// latched bus request record and timeout counter sizing.
package rv32i_mem_pkg;

   localparam int XLEN = 32;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;
   localparam int TIMEOUT_W = $clog2(DEFAULT_TIMEOUT_CYCLES);
   localparam logic [3:0] BYTE_EN_ALL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA_ACC,
      ST_FETCH_ACC,
      ST_DATA_RESP,
      ST_FETCH_RESP
   } arb_state_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [3:0]      byte_en;
      logic            we;
   } bus_req_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting for a bus acknowledge; expired is raised in the
// last allowed cycle so the owner can abort on the same edge.
module mem_timeout_counter
   import rv32i_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = TIMEOUT_W
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter_rv32i.sv
// Single-port memory arbiter for the RV32I pipeline: one bus transaction at a
// time, loads/stores win over fetches, one-cycle ready pulse per completion.
module mem_port_arbiter_rv32i
   import rv32i_mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_request,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instruction_ready,
   input  logic                  data_read_M,
   input  logic                  data_write_M,
   input  logic [ADDR_WIDTH-1:0] data_address_M,
   input  logic [DATA_WIDTH-1:0] data_wdata_M,
   input  logic [3:0]            data_byte_en_M,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  data_ready,
   output logic                  mem_transaction,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   output logic [3:0]            bus_byte_en,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic                  bus_error
);

   arb_state_t state, state_next;
   bus_req_t   req_q;
   logic       data_req;
   logic       in_acc;
   logic       to_expired;

   assign data_req = data_read_M | data_write_M;
   assign in_acc   = (state == ST_DATA_ACC) || (state == ST_FETCH_ACC);

   mem_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          ($clog2(TIMEOUT_CYCLES))
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_acc),
      .enable  (in_acc),
      .expired (to_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // RESP always returns to IDLE so a level-held request that just completed
   // is not sampled again before the pipeline has advanced.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (data_req) begin
               state_next = ST_DATA_ACC;
            end else if (fetch_request) begin
               state_next = ST_FETCH_ACC;
            end
         end
         ST_DATA_ACC: begin
            if (bus_ack || to_expired) begin
               state_next = ST_DATA_RESP;
            end
         end
         ST_FETCH_ACC: begin
            if (bus_ack || to_expired) begin
               state_next = ST_FETCH_RESP;
            end
         end
         ST_DATA_RESP:  state_next = ST_IDLE;
         ST_FETCH_RESP: state_next = ST_IDLE;
         default:       state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_req           = 1'b0;
      instruction_ready = 1'b0;
      data_ready        = 1'b0;
      case (state)
         ST_DATA_ACC, ST_FETCH_ACC: bus_req           = 1'b1;
         ST_FETCH_RESP:             instruction_ready = 1'b1;
         ST_DATA_RESP:              data_ready        = 1'b1;
         default: ;
      endcase
      mem_transaction = data_req && (state != ST_DATA_RESP);
   end

   // Request is latched only in IDLE, which keeps bus_* stable for the whole access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q <= '0;
      end else if (state == ST_IDLE) begin
         if (data_req) begin
            req_q.addr    <= data_address_M;
            req_q.wdata   <= data_wdata_M;
            req_q.we      <= data_write_M;
            req_q.byte_en <= data_write_M ? data_byte_en_M : BYTE_EN_ALL;
         end else if (fetch_request) begin
            req_q.addr    <= fetch_address;
            req_q.wdata   <= '0;
            req_q.we      <= 1'b0;
            req_q.byte_en <= BYTE_EN_ALL;
         end
      end
   end

   assign bus_we      = req_q.we;
   assign bus_addr    = req_q.addr;
   assign bus_wdata   = req_q.wdata;
   assign bus_byte_en = req_q.byte_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= '0;
         data_rdata  <= '0;
         bus_error   <= 1'b0;
      end else begin
         if (state == ST_FETCH_ACC) begin
            if (bus_ack) begin
               instruction <= bus_rdata;
            end else if (to_expired) begin
               instruction <= '0;
            end
         end
         if ((state == ST_DATA_ACC) && !req_q.we) begin
            if (bus_ack) begin
               data_rdata <= bus_rdata;
            end else if (to_expired) begin
               data_rdata <= '0;
            end
         end
         if (in_acc && !bus_ack && to_expired) begin
            bus_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter_rv32i.sv
// Scoreboard bench for mem_port_arbiter_rv32i: a driver issues pipeline-style
// requests and queues expectations, a negedge monitor/bus slave checks them.
`timescale 1ns/1ps
module tb_mem_port_arbiter_rv32i;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_request = 1'b0;
   logic [31:0] fetch_address = '0;
   logic [31:0] instruction;
   logic        instruction_ready;
   logic        data_read_M = 1'b0;
   logic        data_write_M = 1'b0;
   logic [31:0] data_address_M = '0;
   logic [31:0] data_wdata_M = '0;
   logic [3:0]  data_byte_en_M = '0;
   logic [31:0] data_rdata;
   logic        data_ready;
   logic        mem_transaction;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_byte_en;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        bus_error;

   mem_port_arbiter_rv32i #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_request(fetch_request), .fetch_address(fetch_address),
      .instruction(instruction), .instruction_ready(instruction_ready),
      .data_read_M(data_read_M), .data_write_M(data_write_M),
      .data_address_M(data_address_M), .data_wdata_M(data_wdata_M),
      .data_byte_en_M(data_byte_en_M), .data_rdata(data_rdata),
      .data_ready(data_ready), .mem_transaction(mem_transaction),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: got no event, required one (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   // Memory map: fetches live below 0x1000, data accesses at 0x1000 and above.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
   } bus_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] data;
   } dresp_t;

   bus_exp_t    fbus_q[$];
   bus_exp_t    dbus_q[$];
   logic [31:0] fresp_q[$];
   dresp_t      dresp_q[$];

   // Environment / model state shared between driver and monitor.
   bit          slave_no_ack = 1'b0;
   int          forced_delay = -1;
   bit          force_rdata_en = 1'b0;
   logic [31:0] force_rdata = '0;
   bit          err_model = 1'b0;
   logic [31:0] last_rdata = '0;
   int          fetch_done = 0;
   int          data_done = 0;
   int          last_iready_cyc = 0;
   int          last_dready_cyc = 0;

   // Monitor-private state.
   bit          resp_due = 1'b0;
   bit          resp_is_fetch = 1'b0;
   bit          resp_to = 1'b0;
   bit          prev_req = 1'b0;
   int          req_cnt = 0;
   int          cur_delay = 0;
   bit          cur_is_fetch = 1'b0;
   bit          mi, md;
   bus_exp_t    be_e;
   dresp_t      de;
   logic [31:0] fe;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_be;
   logic        obs_we;

   always @(negedge clk) begin
      if (!rst_n) begin
         check1("rst_bus_req", bus_req, 1'b0);
         check1("rst_instruction_ready", instruction_ready, 1'b0);
         check1("rst_data_ready", data_ready, 1'b0);
         check1("rst_bus_error", bus_error, 1'b0);
         resp_due = 1'b0;
         prev_req = 1'b0;
         req_cnt  = 0;
         bus_ack  = 1'b0;
      end else begin
         mi = resp_due && resp_is_fetch;
         md = resp_due && !resp_is_fetch;
         if (md && resp_to) err_model = 1'b1;
         check1("instruction_ready", instruction_ready, mi);
         check1("data_ready", data_ready, md);
         if (mi) begin
            if (fresp_q.size() == 0) fail_now("fetch_resp_expected");
            else begin
               fe = fresp_q.pop_front();
               check32("instruction", instruction, fe);
            end
            fetch_done++;
            last_iready_cyc = cyc;
         end
         if (md) begin
            if (dresp_q.size() == 0) fail_now("data_resp_expected");
            else begin
               de = dresp_q.pop_front();
               if (de.we) check32("data_rdata_hold", data_rdata, last_rdata);
               else begin
                  check32("data_rdata", data_rdata, de.data);
                  last_rdata = de.data;
               end
            end
            data_done++;
            last_dready_cyc = cyc;
         end
         check1("bus_error", bus_error, err_model);
         check1("mem_transaction", mem_transaction, (data_read_M | data_write_M) && !md);
         resp_due = 1'b0;

         if (bus_req) begin
            if (!prev_req) begin
               req_cnt = 1;
               cur_is_fetch = (bus_addr < 32'h1000);
               obs_addr = bus_addr; obs_wdata = bus_wdata; obs_be = bus_byte_en; obs_we = bus_we;
               if (cur_is_fetch ? (fbus_q.size() == 0) : (dbus_q.size() == 0))
                  fail_now("bus_txn_expected");
               else begin
                  be_e = cur_is_fetch ? fbus_q.pop_front() : dbus_q.pop_front();
                  check32("bus_addr", bus_addr, be_e.addr);
                  check1("bus_we", bus_we, be_e.we);
                  check32("bus_byte_en", {28'h0, bus_byte_en}, {28'h0, be_e.be});
                  if (be_e.we) check32("bus_wdata", bus_wdata, be_e.wdata);
               end
               cur_delay = (forced_delay >= 0) ? forced_delay : $urandom_range(0, 3);
            end else begin
               req_cnt++;
               check32("bus_stable",
                       {28'h0, obs_addr == bus_addr, obs_we == bus_we,
                        obs_be == bus_byte_en, obs_wdata == bus_wdata}, 32'hF);
               if (req_cnt == TO + 1) fail_now("bus_req_timeout_abort");
            end
            if (!slave_no_ack && (req_cnt - 1 == cur_delay)) begin
               bus_ack = 1'b1;
               bus_rdata = force_rdata_en ? force_rdata : mem_fn(bus_addr);
               resp_due = 1'b1; resp_is_fetch = cur_is_fetch; resp_to = 1'b0;
            end else begin
               bus_ack = 1'b0;
               bus_rdata = $urandom;
               if (req_cnt == TO) begin
                  resp_due = 1'b1; resp_is_fetch = cur_is_fetch; resp_to = 1'b1;
               end
            end
         end else begin
            req_cnt = 0;
            bus_ack = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
         end
         prev_req = bus_req;
      end
   end

   task automatic start_fetch(input logic [31:0] a, input logic [31:0] exp);
      fetch_request = 1'b1;
      fetch_address = a;
      fbus_q.push_back('{a, 32'h0, 4'hF, 1'b0});
      fresp_q.push_back(exp);
   endtask

   task automatic start_data(input logic [31:0] a, input bit rd, input bit wr,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic [31:0] exp);
      data_read_M = rd;
      data_write_M = wr;
      data_address_M = a;
      data_wdata_M = wd;
      data_byte_en_M = be;
      dbus_q.push_back('{a, wd, wr ? be : 4'hF, wr});
      dresp_q.push_back('{wr, exp});
   endtask

   // Each request is held until its ready pulse, then dropped the next cycle.
   task automatic wait_done(input int f0, input int d0, input bit wf, input bit wd);
      for (int t = 0; t < 400 && (wf || wd); t++) begin
         @(posedge clk); #1;
         if (wf && fetch_done != f0) begin fetch_request = 1'b0; wf = 1'b0; end
         if (wd && data_done != d0) begin data_read_M = 1'b0; data_write_M = 1'b0; wd = 1'b0; end
      end
      if (wf || wd) begin
         fetch_request = 1'b0; data_read_M = 1'b0; data_write_M = 1'b0;
         fail_now("response_within_bound");
      end
   endtask

   int          f0, d0, issue_cyc, prev_rc, tw, kind, gap, op;
   bit          wf, wd;
   logic [31:0] a, wdat;

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check32("rst_instruction", instruction, 32'h0);
      check32("rst_data_rdata", data_rdata, 32'h0);
      check32("rst_bus_addr", bus_addr, 32'h0);
      check1("rst_bus_we", bus_we, 1'b0);
      check32("rst_bus_byte_en", {28'h0, bus_byte_en}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Fetch only, ack in the second ACC cycle.
      forced_delay = 1; force_rdata_en = 1'b1; force_rdata = 32'h0051_0113;
      f0 = fetch_done; d0 = data_done;
      @(posedge clk); #1;
      start_fetch(32'h40, 32'h0051_0113);
      wait_done(f0, d0, 1'b1, 1'b0);
      force_rdata_en = 1'b0;

      // Simultaneous fetch and load: load goes first, fetch follows after RESP.
      forced_delay = 0;
      f0 = fetch_done; d0 = data_done;
      @(posedge clk); #1;
      start_fetch(32'h44, mem_fn(32'h44));
      start_data(32'h1000, 1'b1, 1'b0, 32'h0, 4'h0, mem_fn(32'h1000));
      wait_done(f0, d0, 1'b1, 1'b1);
      check32("data_before_fetch_gap", last_iready_cyc - last_dready_cyc, 32'd3);

      // Store with immediate ack: ready in the third cycle counting the request cycle.
      f0 = fetch_done; d0 = data_done;
      @(posedge clk); #1;
      issue_cyc = cyc;
      start_data(32'h2008, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'h0);
      wait_done(f0, d0, 1'b0, 1'b1);
      check32("store_latency", last_dready_cyc - issue_cyc, 32'd2);

      // Load that is never acknowledged.
      forced_delay = -1; slave_no_ack = 1'b1;
      f0 = fetch_done; d0 = data_done;
      @(posedge clk); #1;
      start_data(32'h1004, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
      wait_done(f0, d0, 1'b0, 1'b1);
      slave_no_ack = 1'b0;
      check1("bus_error_after_timeout", bus_error, 1'b1);

      // Back-to-back fetches with the request held and address advanced on ready.
      forced_delay = 0;
      f0 = fetch_done;
      prev_rc = 0;
      @(posedge clk); #1;
      start_fetch(32'h100, mem_fn(32'h100));
      for (int k = 0; k < 5; k++) begin
         tw = 0;
         while (fetch_done == f0 + k && tw < 50) begin
            @(posedge clk); #1;
            tw++;
         end
         if (tw >= 50) fail_now("b2b_ready");
         if (k > 0) check32("b2b_spacing", last_iready_cyc - prev_rc, 32'd3);
         prev_rc = last_iready_cyc;
         if (k < 4) start_fetch(32'h100 + 32'(4 * (k + 1)), mem_fn(32'h100 + 32'(4 * (k + 1))));
         else fetch_request = 1'b0;
      end

      // Reset in the middle of a data access; the held load restarts afterwards.
      slave_no_ack = 1'b1;
      d0 = data_done;
      @(posedge clk); #1;
      start_data(32'h1010, 1'b1, 1'b0, 32'h0, 4'h0, mem_fn(32'h1010));
      repeat (5) @(posedge clk);
      #1;
      check1("bus_req_before_reset", bus_req, 1'b1);
      rst_n = 1'b0;
      err_model = 1'b0;
      last_rdata = '0;
      #1;
      check1("reset_bus_req_immediate", bus_req, 1'b0);
      check1("reset_bus_error_clear", bus_error, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check32("reset_no_data_ready", data_done - d0, 32'd0);
      slave_no_ack = 1'b0;
      dbus_q.push_back('{32'h1010, 32'h0, 4'hF, 1'b0});
      rst_n = 1'b1;
      wait_done(fetch_done, d0, 1'b0, 1'b1);

      // Randomized traffic.
      forced_delay = -1;
      for (int r = 0; r < 150; r++) begin
         kind = $urandom_range(0, 3);
         gap = $urandom_range(1, 2);
         op = $urandom_range(0, 2);
         f0 = fetch_done; d0 = data_done; wf = 1'b0; wd = 1'b0;
         a = 32'h1000 + 32'($urandom_range(0, 1023) << 2);
         wdat = $urandom;
         @(posedge clk); #1;
         if (kind != 1) begin
            start_fetch(32'($urandom_range(0, 1023) << 2), 32'h0);
            void'(fresp_q.pop_back());
            fresp_q.push_back(mem_fn(fetch_address));
            wf = 1'b1;
         end
         if (kind == 3) repeat (gap) begin @(posedge clk); #1; end
         if (kind != 0) begin
            start_data(a, op != 1, op != 0, wdat, 4'($urandom_range(0, 15)), mem_fn(a));
            wd = 1'b1;
         end
         wait_done(f0, d0, wf, wd);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      #1;
      check32("queues_drained",
              32'(fbus_q.size() + dbus_q.size() + fresp_q.size() + dresp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
